// File: rtl/vec_cache_pkg.sv
// Shared types and the per-way merge rule for the dirty-mask update controller.
package vec_cache_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_SET    = 2'd1,
    OP_CLR    = 2'd2,
    OP_RSVD   = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    FL_IDLE,
    FL_RUN,
    FL_DRAIN,
    FL_SWEEP,
    FL_DONE
  } flush_st_e;

  function automatic logic merge_bit(req_op_e op, logic base, logic mask);
    case (op)
      OP_SET:  return base | mask;
      OP_CLR:  return base & ~mask;
      default: return base;
    endcase
  endfunction

  function automatic logic op_writes(req_op_e op);
    return (op == OP_SET) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/vec_cache_tag_upd_ctrl.sv
// Dirty-mask read-merge-write controller with a flush sweep.
// Optional macro VEC_CACHE_TAG_FWD_EN: forward S2 result into S1 for same-index ops.
module vec_cache_tag_upd_ctrl
  import vec_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [ADDR_WIDTH-1:0] req_idx,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_mask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_old,
  output logic [DATA_WIDTH-1:0] rsp_new,
  output logic                  arr_rd_en,
  output logic [ADDR_WIDTH-1:0] arr_rd_addr,
  input  logic [DATA_WIDTH-1:0] arr_rd_data,
  output logic                  arr_wr_en,
  output logic [ADDR_WIDTH-1:0] arr_wr_addr,
  output logic [DATA_WIDTH-1:0] arr_wr_data,
  input  logic                  flush_req,
  output logic                  flush_done
);

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  logic                  s1_vld_q;
  logic [ADDR_WIDTH-1:0] s1_idx_q;
  req_op_e               s1_op_q;
  logic [DATA_WIDTH-1:0] s1_mask_q;

  logic                  s2_vld_q;
  logic [DATA_WIDTH-1:0] rsp_old_q;
  logic [DATA_WIDTH-1:0] rsp_new_q;
`ifdef VEC_CACHE_TAG_FWD_EN
  logic [ADDR_WIDTH-1:0] s2_idx_q;
  logic                  s2_wr_q;
`endif

  flush_st_e             st_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  flush_done_q;

  logic                  s1_adv;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] base_d;
  logic [DATA_WIDTH-1:0] new_d;

  assign s1_adv = s1_vld_q && (!s2_vld_q || rsp_rdy);

`ifdef VEC_CACHE_TAG_FWD_EN
  assign req_rdy = (st_q == FL_RUN) && (!s1_vld_q || s1_adv);
`else
  // Without forwarding, a same-index request must wait until the pending write lands.
  assign req_rdy = (st_q == FL_RUN) && (!s1_vld_q || s1_adv) &&
                   !(s1_vld_q && op_writes(s1_op_q) && (s1_idx_q == req_idx));
`endif

  assign xfer        = req_vld && req_rdy;
  assign arr_rd_en   = xfer;
  assign arr_rd_addr = req_idx;

  assign rsp_vld    = s2_vld_q;
  assign rsp_old    = rsp_old_q;
  assign rsp_new    = rsp_new_q;
  assign flush_done = flush_done_q;

  always_comb begin
    base_d = arr_rd_data;
`ifdef VEC_CACHE_TAG_FWD_EN
    if (s2_vld_q && s2_wr_q && (s2_idx_q == s1_idx_q)) begin
      base_d = rsp_new_q;
    end
`endif
  end

  always_comb begin
    new_d = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      new_d[i] = merge_bit(s1_op_q, base_d[i], s1_mask_q[i]);
    end
  end

  always_comb begin
    if (st_q == FL_SWEEP) begin
      arr_wr_en   = 1'b1;
      arr_wr_addr = cnt_q;
      arr_wr_data = '0;
    end else begin
      arr_wr_en   = s1_adv && op_writes(s1_op_q);
      arr_wr_addr = s1_idx_q;
      arr_wr_data = new_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_idx_q  <= '0;
      s1_op_q   <= OP_LOOKUP;
      s1_mask_q <= '0;
      s2_vld_q  <= 1'b0;
      rsp_old_q <= '0;
      rsp_new_q <= '0;
`ifdef VEC_CACHE_TAG_FWD_EN
      s2_idx_q  <= '0;
      s2_wr_q   <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        s1_vld_q  <= 1'b1;
        s1_idx_q  <= req_idx;
        s1_op_q   <= req_op_e'(req_op);
        s1_mask_q <= req_mask;
      end else if (s1_adv) begin
        s1_vld_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_vld_q  <= 1'b1;
        rsp_old_q <= base_d;
        rsp_new_q <= new_d;
`ifdef VEC_CACHE_TAG_FWD_EN
        s2_idx_q  <= s1_idx_q;
        s2_wr_q   <= op_writes(s1_op_q);
`endif
      end else if (rsp_rdy) begin
        s2_vld_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= FL_IDLE;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (st_q)
        FL_IDLE: st_q <= FL_RUN;
        FL_RUN: begin
          if (flush_req) st_q <= FL_DRAIN;
        end
        FL_DRAIN: begin
          if (!s1_vld_q && !s2_vld_q) st_q <= FL_SWEEP;
        end
        FL_SWEEP: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == '1) begin
            st_q         <= FL_DONE;
            flush_done_q <= 1'b1;
          end
        end
        FL_DONE: begin
          st_q  <= FL_RUN;
          cnt_q <= '0;
        end
        default: st_q <= FL_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vec_cache_tag_upd_ctrl.md
VEC_CACHE_TAG_UPD_CTRL -- requirements
Module: vec_cache_tag_upd_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, index width; DATA_WIDTH, default 4, dirty-mask width (one bit per way).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_vld / req_rdy  input / output  1 / 1  request handshake; transfer when both are high.
REQ-005 req_idx  input  ADDR_WIDTH  set index.
REQ-006 req_op  input  2  operation: 0 LOOKUP, 1 SET, 2 CLR, 3 reserved (treated as LOOKUP).
REQ-007 req_mask  input  DATA_WIDTH  way bits affected by SET/CLR.
REQ-008 rsp_vld / rsp_rdy  output / input  1 / 1  response handshake.
REQ-009 rsp_old / rsp_new  output  DATA_WIDTH each  dirty mask before and after the op.
REQ-010 arr_rd_en, arr_rd_addr  output  1, ADDR_WIDTH  array read port; arr_rd_data (input, DATA_WIDTH) is valid one cycle later and held until the next arr_rd_en.
REQ-011 arr_wr_en, arr_wr_addr, arr_wr_data  output  1, ADDR_WIDTH, DATA_WIDTH  array write port.
REQ-012 flush_req  input  1  single-cycle pulse requesting clear of all dirty bits; flush_done  output  1  single-cycle completion pulse.

Function
REQ-013 Two-stage pipeline: S1 (read-merge-write) and S2 (response register).
REQ-014 On a transfer, arr_rd_en SHALL be asserted combinationally in the same cycle with arr_rd_addr = req_idx; the request is captured into S1 at that edge.
REQ-015 S1 base value = forwarded S2 data when S2 holds a SET/CLR to the same index (under the macro), else arr_rd_data.
REQ-016 S1 new value: SET = base | mask; CLR = base & ~mask; LOOKUP = base.
REQ-017 S1 SHALL assert arr_wr_en for SET/CLR only in the cycle S1 advances to S2; LOOKUP never writes.
REQ-018 S1 advances when S2 is empty or (rsp_vld && rsp_rdy); otherwise S1 and S2 hold and arr_wr_en stays low.
REQ-019 req_rdy = FSM in RUN and (S1 empty or S1 advancing), subject to REQ-028.
REQ-020 Request-to-response latency SHALL be 2 cycles with no backpressure; throughput one op per cycle.
REQ-021 rsp_vld, rsp_old and rsp_new SHALL stay stable while rsp_vld && !rsp_rdy.
REQ-022 Flush FSM states and transitions:
- IDLE: transitions to RUN one cycle after reset release.
- RUN: flush_req moves to DRAIN.
- DRAIN: req_rdy = 0; moves to SWEEP once S1 and S2 are empty.
- SWEEP: writes 0 to index cnt each cycle, cnt 0..2^ADDR_WIDTH-1; moves to DONE after the last index.
- DONE: flush_done = 1 for one cycle, then RUN.
REQ-023 flush_req outside RUN SHALL be ignored; flush_req and req_vld in the same RUN cycle: request accepted, then drained.
REQ-024 Sweep counter SHALL wrap to 0 on DONE; no arr_rd_en during SWEEP.

Reset
REQ-025 Reset SHALL clear the following: S1/S2 valid; FSM to IDLE; sweep counter to 0; rsp_vld, rsp_old, rsp_new, flush_done to 0; req_rdy, arr_rd_en, arr_wr_en low.
REQ-026 Reset mid-sweep or mid-pipeline SHALL abandon the operation with no further array writes; the array's own reset restores contents.

Configuration
REQ-027 Macro VEC_CACHE_TAG_FWD_EN defined: S2-to-S1 forwarding per REQ-015; back-to-back same-index ops run at full rate.
REQ-028 Macro undefined: no forwarding; req_rdy SHALL be low while S1 holds a SET/CLR whose index equals req_idx, costing one bubble.

Structure
REQ-029 A shared package vec_cache_pkg SHALL hold the req_op enum, the flush FSM state enum and the merge function.
REQ-030 No sub-module is required; the block SHALL be flat.

Verification
REQ-031 Reset, then SET idx 5 mask 4'b0011 -> rsp after 2 cycles with old 0000, new 0011; arr_wr_en once, addr 5, data 0011.
REQ-032 Back-to-back SET idx 7 mask 0001, then SET idx 7 mask 0100 -> with macro: rsp_new 0001 then 0101, no bubble; without macro: one req_rdy-low cycle and the same values.
REQ-033 CLR idx 7 mask 0001 after REQ-032 -> old 0101, new 0100; LOOKUP idx 7 -> 0100/0100 with no write.
REQ-034 Hold rsp_rdy low 3 cycles with 2 ops in flight -> rsp stable, req_rdy low, no arr_wr_en until release.
REQ-035 flush_req with ADDR_WIDTH=3 after dirtying idx 2 -> 8 zero writes idx 0..7, then flush_done pulse; LOOKUP idx 2 -> 0000.
REQ-036 Assert rst_n low at sweep cnt 3 -> no further writes; after release, FSM RUN and flush_done stays 0.
